// File: rtl/axibram_pkg.sv
// Shared constants and types for the AXI3 write-burst to BRAM bridge.
package axibram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, BURST} wr_state_t;

    // WRAP only wraps for power-of-two burst lengths; anything else behaves as INCR.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axibram_sfifo.sv
// Synchronous-reset register FIFO with occupancy-based empty/full flags.
module axibram_sfifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             nempty,
    output logic             full
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q;
    logic [LOG2_DEPTH-1:0] rd_ptr_q;
    logic [LOG2_DEPTH:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & nempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata  = mem_q[rd_ptr_q];
    assign nempty = (count_q != '0);
    assign full   = (count_q == FULL_CNT);

endmodule

// File: rtl/axibram_write_burst.sv
// AXI3 write-channel slave to BRAM bridge: one B response per burst, FIXED/INCR/WRAP addressing.
// Optional wid/wlast checking is enabled by defining AXIBRAM_WRITE_ERRCHK_EN.
module axibram_write_burst
    import axibram_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 12,
    parameter int unsigned FIFO_LOG2    = 2
) (
    input  logic                      aclk,
    input  logic                      rst,
    input  logic [31:0]               awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [3:0]                awlen,
    input  logic [1:0]                awburst,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [ID_WIDTH-1:0]       wid,
    input  logic                      wlast,
    input  logic [DATA_WIDTH/8-1:0]   wstb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic [ADDRESS_BITS-1:0]   pre_awaddr,
    output logic                      start_burst,
    input  logic                      dev_ready,
    output logic [ADDRESS_BITS-1:0]   bram_waddr,
    output logic                      bram_wen,
    output logic [DATA_WIDTH/8-1:0]   bram_wstb,
    output logic [DATA_WIDTH-1:0]     bram_wdata
);

    localparam int unsigned LSB   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned STB_W = DATA_WIDTH / 8;
    localparam int unsigned AW_W  = ID_WIDTH + 4 + 2 + ADDRESS_BITS;
    localparam int unsigned B_W   = ID_WIDTH + 2;
`ifdef AXIBRAM_WRITE_ERRCHK_EN
    localparam int unsigned W_W   = ID_WIDTH + 1 + STB_W + DATA_WIDTH;
`else
    localparam int unsigned W_W   = STB_W + DATA_WIDTH;
`endif

    // AW FIFO
    logic [AW_W-1:0]         aw_wdata, aw_rdata;
    logic                    aw_push, aw_nempty, aw_full;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [3:0]              aw_len;
    logic [1:0]              aw_burst;
    logic [ADDRESS_BITS-1:0] aw_addr;

    // W FIFO
    logic [W_W-1:0]          w_wdata, w_rdata;
    logic                    w_push, w_nempty, w_full;

    // B FIFO
    logic [B_W-1:0]          b_wdata, b_rdata;
    logic                    b_push, b_pop, b_full;

    wr_state_t               state_q, state_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [3:0]              left_q, left_d;
    logic [3:0]              len_q, len_d;
    logic [1:0]              burst_q, burst_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    err_q, err_d;
    logic                    dev_ready_r;
    logic                    beat_err;

    logic unused_awaddr;
    assign unused_awaddr = ^{awaddr[31:ADDRESS_BITS+LSB], awaddr[LSB-1:0]};

    assign awready  = ~aw_full & ~rst;
    assign aw_push  = awvalid & awready;
    assign aw_wdata = {awid, awlen, awburst, awaddr[ADDRESS_BITS+LSB-1:LSB]};
    assign {aw_id, aw_len, aw_burst, aw_addr} = aw_rdata;
    assign pre_awaddr = aw_addr;

    assign wready = ~w_full & ~rst;
    assign w_push = wvalid & wready;

`ifdef AXIBRAM_WRITE_ERRCHK_EN
    logic [ID_WIDTH-1:0] w_id;
    logic                w_last;
    assign w_wdata = {wid, wlast, wstb, wdata};
    assign {w_id, w_last, bram_wstb, bram_wdata} = w_rdata;
    assign beat_err = (w_id != id_q) | (w_last != (left_q == 4'd0));
`else
    logic unused_w;
    assign unused_w = ^{wid, wlast};
    assign w_wdata  = {wstb, wdata};
    assign {bram_wstb, bram_wdata} = w_rdata;
    assign beat_err = 1'b0;
`endif

    assign b_wdata = {id_q, (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY};
    assign b_pop   = bvalid & bready;
    assign {bid, bresp} = b_rdata;

    assign bram_waddr = addr_q;

    function automatic logic [ADDRESS_BITS-1:0] next_addr(
        input logic [ADDRESS_BITS-1:0] a,
        input logic [3:0]              len,
        input logic [1:0]              burst
    );
        logic [ADDRESS_BITS-1:0] mask;
        logic [ADDRESS_BITS-1:0] inc;
        mask = {{(ADDRESS_BITS-4){1'b0}}, len};
        inc  = a + 1'b1;
        if (burst == BURST_FIXED) return a;
        if ((burst == BURST_WRAP) && wrap_len_ok(len)) return (a & ~mask) | (inc & mask);
        return inc;
    endfunction

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            left_q      <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            dev_ready_r <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            len_q       <= len_d;
            burst_q     <= burst_d;
            id_q        <= id_d;
            err_q       <= err_d;
            dev_ready_r <= dev_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        left_d      = left_q;
        len_d       = len_q;
        burst_d     = burst_q;
        id_d        = id_q;
        err_d       = err_q;
        start_burst = 1'b0;
        bram_wen    = 1'b0;
        b_push      = 1'b0;
        unique case (state_q)
            IDLE: start_burst = aw_nempty;
            BURST: begin
                bram_wen = w_nempty & dev_ready_r & ~b_full;
                if (bram_wen) begin
                    err_d = err_q | beat_err;
                    if (left_q == 4'd0) begin
                        b_push      = 1'b1;
                        state_d     = IDLE;
                        start_burst = aw_nempty;
                    end else begin
                        left_d = left_q - 4'd1;
                        addr_d = next_addr(addr_q, len_q, burst_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            start_burst = 1'b0;
            bram_wen    = 1'b0;
            b_push      = 1'b0;
        end
        // A new burst load overrides the decrement of the finishing one.
        if (start_burst) begin
            state_d = BURST;
            addr_d  = aw_addr;
            left_d  = aw_len;
            len_d   = aw_len;
            burst_d = aw_burst;
            id_d    = aw_id;
            err_d   = 1'b0;
        end
    end

    axibram_sfifo #(.WIDTH(AW_W), .LOG2_DEPTH(FIFO_LOG2)) u_aw_fifo (
        .clk    (aclk),
        .rst    (rst),
        .push   (aw_push),
        .wdata  (aw_wdata),
        .pop    (start_burst),
        .rdata  (aw_rdata),
        .nempty (aw_nempty),
        .full   (aw_full)
    );

    axibram_sfifo #(.WIDTH(W_W), .LOG2_DEPTH(FIFO_LOG2)) u_w_fifo (
        .clk    (aclk),
        .rst    (rst),
        .push   (w_push),
        .wdata  (w_wdata),
        .pop    (bram_wen),
        .rdata  (w_rdata),
        .nempty (w_nempty),
        .full   (w_full)
    );

    axibram_sfifo #(.WIDTH(B_W), .LOG2_DEPTH(FIFO_LOG2)) u_b_fifo (
        .clk    (aclk),
        .rst    (rst),
        .push   (b_push),
        .wdata  (b_wdata),
        .pop    (b_pop),
        .rdata  (b_rdata),
        .nempty (bvalid),
        .full   (b_full)
    );

endmodule

// File: tb/tb_axibram_write_burst.sv
// Self-checking bench for axibram_write_burst: directed cases plus randomized bursts vs. a queue model.
module tb_axibram_write_burst;

    localparam int AB  = 10;
    localparam int DW  = 32;
    localparam int IDW = 12;
    localparam int SW  = DW / 8;
    localparam int LSB = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    awaddr;
    logic           awvalid, awready;
    logic [IDW-1:0] awid;
    logic [3:0]     awlen;
    logic [1:0]     awburst;
    logic [DW-1:0]  wdata;
    logic           wvalid, wready;
    logic [IDW-1:0] wid;
    logic           wlast;
    logic [SW-1:0]  wstb;
    logic           bvalid, bready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic [AB-1:0]  pre_awaddr;
    logic           start_burst, dev_ready;
    logic [AB-1:0]  bram_waddr;
    logic           bram_wen;
    logic [SW-1:0]  bram_wstb;
    logic [DW-1:0]  bram_wdata;

    always #5 clk = ~clk;

    axibram_write_burst dut (
        .aclk        (clk),
        .rst         (rst),
        .awaddr      (awaddr),
        .awvalid     (awvalid),
        .awready     (awready),
        .awid        (awid),
        .awlen       (awlen),
        .awburst     (awburst),
        .wdata       (wdata),
        .wvalid      (wvalid),
        .wready      (wready),
        .wid         (wid),
        .wlast       (wlast),
        .wstb        (wstb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bid         (bid),
        .bresp       (bresp),
        .pre_awaddr  (pre_awaddr),
        .start_burst (start_burst),
        .dev_ready   (dev_ready),
        .bram_waddr  (bram_waddr),
        .bram_wen    (bram_wen),
        .bram_wstb   (bram_wstb),
        .bram_wdata  (bram_wdata)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_aw_cyc;
    int b_count;
    logic dr_prev = 1'b0;
    logic bv_prev = 1'b0;

    // Reference model: expected beat addresses (from AW), beat payloads (from W), responses.
    int unsigned           exp_addr_q[$];
    logic [SW+DW-1:0]      exp_data_q[$];
    logic [IDW+1:0]        exp_b_q[$];
    int                    wen_log[$];
    int unsigned           wa_log[$];
    int                    sb_log[$];
    int                    bv_log[$];
    logic [1:0]            bresp_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        dr_prev <= rst ? 1'b0 : dev_ready;
    end

    always @(negedge clk) begin
        logic [SW+DW-1:0] d;
        logic [IDW+1:0]   b;
        if (!rst) begin
            if (bram_wen) begin
                wen_log.push_back(cyc);
                wa_log.push_back(int'(bram_waddr));
                check("wen_needs_dev_ready_r", dr_prev, 1);
                if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
                    check("unexpected_beat", exp_addr_q.size() * exp_data_q.size(), 1);
                end else begin
                    check("bram_waddr", bram_waddr, exp_addr_q.pop_front());
                    d = exp_data_q.pop_front();
                    check("bram_wstb_wdata", {bram_wstb, bram_wdata}, d);
                end
            end
            if (start_burst) sb_log.push_back(cyc);
            if (bvalid && !bv_prev) bv_log.push_back(cyc);
            if (bvalid && bready) begin
                b_count++;
                bresp_log.push_back(bresp);
                if (exp_b_q.size() == 0) begin
                    check("unexpected_b", exp_b_q.size(), 1);
                end else begin
                    b = exp_b_q.pop_front();
                    check("bid_bresp", {bid, bresp}, b);
                end
            end
        end
        bv_prev <= bvalid;
    end

    function automatic int unsigned beat_addr(int unsigned a, int unsigned len, int unsigned burst,
                                              int unsigned i);
        int unsigned n = len + 1;
        if (burst == 0) return a;
        if (burst == 2 && (n == 2 || n == 4 || n == 8 || n == 16)) return (a - a % n) + (a % n + i) % n;
        return (a + i) % (1 << AB);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wen_log.delete(); wa_log.delete(); sb_log.delete(); bv_log.delete(); bresp_log.delete();
        b_count = 0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input int len, input int burst,
                           input logic [IDW-1:0] id, input bit err_exp);
        int n = 0;
        int unsigned a;
        logic [1:0] resp;
        awaddr = addr; awlen = 4'(len); awburst = 2'(burst); awid = id; awvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (awready) break;
            n++;
            if (n > 500) begin check("awready_timeout", awready, 1); break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        last_aw_cyc = cyc;
        a = (addr >> LSB) % (1 << AB);
        for (int i = 0; i <= len; i++) exp_addr_q.push_back(beat_addr(a, len, burst, i));
`ifdef AXIBRAM_WRITE_ERRCHK_EN
        resp = err_exp ? 2'b10 : 2'b00;
`else
        resp = 2'b00;
`endif
        exp_b_q.push_back({id, resp});
    endtask

    task automatic send_w(input logic [IDW-1:0] id, input bit last);
        int n = 0;
        wdata = $urandom; wstb = 4'($urandom); wid = id; wlast = last; wvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (wready) break;
            n++;
            if (n > 500) begin check("wready_timeout", wready, 1); break; end
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
        exp_data_q.push_back({wstb, wdata});
    endtask

    task automatic send_burst(input logic [31:0] addr, input int len, input int burst,
                              input logic [IDW-1:0] id, input int bad_beat);
        send_aw(addr, len, burst, id, bad_beat >= 0);
        for (int i = 0; i <= len; i++) send_w((i == bad_beat) ? (id ^ 12'h001) : id, i == len);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_addr_q.size() != 0 || exp_b_q.size() != 0) begin
            tick();
            n++;
            if (n > 3000) begin check("drain_timeout", exp_b_q.size(), 0); break; end
        end
        tick(2);
    endtask

    task automatic check_addrs(input string tag, input int unsigned exp[$]);
        check({tag, "_beats"}, wa_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wa_log.size(); i++) check(tag, wa_log[i], exp[i]);
    endtask

    bit rnd_on;

    initial begin
        rst = 1'b1; awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0; awburst = '0;
        wdata = '0; wvalid = 1'b0; wid = '0; wlast = 1'b0; wstb = '0;
        bready = 1'b1; dev_ready = 1'b1; b_count = 0;
        tick();
        @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", awready, 1);
        check("post_rst_wready", wready, 1);
        check("post_rst_state", {bvalid, bram_wen, start_burst, bid, bresp, bram_waddr}, '0);
        tick();

        // INCR with W preloaded: latency AW -> start_burst -> first wen -> bvalid
        clear_logs();
        for (int i = 0; i < 4; i++) send_w(12'h123, i == 3);
        send_aw(32'h40, 3, 1, 12'h123, 0);
        wait_drain();
        check_addrs("incr_addr", '{32'h10, 32'h11, 32'h12, 32'h13});
        check("incr_sb_count", sb_log.size(), 1);
        if (sb_log.size() > 0) check("incr_sb_latency", sb_log[0], last_aw_cyc);
        if (wen_log.size() == 4) begin
            check("incr_wen_latency", wen_log[0], last_aw_cyc + 1);
            check("incr_wen_contig", wen_log[3], wen_log[0] + 3);
            check("incr_bv_count", bv_log.size(), 1);
            if (bv_log.size() > 0) check("incr_bvalid_latency", bv_log[0], wen_log[3] + 1);
        end
        check("incr_b_count", b_count, 1);

        clear_logs();
        send_burst(32'h38, 3, 2, 12'h0A5, -1);
        wait_drain();
        check_addrs("wrap_addr", '{32'h0E, 32'h0F, 32'h0C, 32'h0D});

        clear_logs();
        send_burst(32'h20, 2, 0, 12'h3C3, -1);
        wait_drain();
        check_addrs("fixed_addr", '{32'h08, 32'h08, 32'h08});
        check("fixed_b_count", b_count, 1);

        // back-to-back bursts
        clear_logs();
        send_w(12'h011, 1'b1);
        send_w(12'h022, 1'b0);
        send_w(12'h022, 1'b1);
        send_aw(32'h100, 0, 1, 12'h011, 0);
        send_aw(32'h200, 1, 1, 12'h022, 0);
        wait_drain();
        check("b2b_sb_count", sb_log.size(), 2);
        if (sb_log.size() == 2) check("b2b_sb_adjacent", sb_log[1], sb_log[0] + 1);
        check("b2b_wen_count", wen_log.size(), 3);
        if (wen_log.size() == 3) check("b2b_wen_contig", wen_log[2], wen_log[0] + 2);
        check("b2b_b_count", b_count, 2);

        // dev_ready 1,0,1 mid-burst
        clear_logs();
        for (int i = 0; i < 4; i++) send_w(12'h044, i == 3);
        send_aw(32'h80, 3, 1, 12'h044, 0);
        tick();
        dev_ready = 1'b0;
        tick(2);
        dev_ready = 1'b1;
        wait_drain();
        check("devrdy_wen_count", wen_log.size(), 4);
        if (wen_log.size() == 4) check("devrdy_gap", wen_log[3] - wen_log[0] > 3, 1);

        // B FIFO full stalls beats and backs up W
        clear_logs();
        bready = 1'b0;
        for (int i = 0; i < 8; i++) send_burst(32'(i * 4), 0, 1, 12'(12'h100 + i), -1);
        tick(4);
        @(negedge clk);
        check("bfull_wready", wready, 0);
        check("bfull_bvalid", bvalid, 1);
        check("bfull_wen_count", wen_log.size(), 4);
        tick();
        bready = 1'b1;
        wait_drain();
        check("bfull_b_count", b_count, 8);
        check("bfull_wen_total", wen_log.size(), 8);

        // wid mismatch on beat 1
        clear_logs();
        send_burst(32'h300, 1, 1, 12'h005, 1);
        wait_drain();
        check("errchk_b_count", bresp_log.size(), 1);
`ifdef AXIBRAM_WRITE_ERRCHK_EN
        if (bresp_log.size() > 0) check("errchk_bresp", bresp_log[0], 2'b10);
`else
        if (bresp_log.size() > 0) check("errchk_bresp", bresp_log[0], 2'b00);
`endif

        // reset during beat 2 of a len=7 burst
        clear_logs();
        for (int i = 0; i < 4; i++) send_w(12'h0EE, 1'b0);
        send_aw(32'h400, 7, 1, 12'h0EE, 0);
        for (int n = 0; n < 50 && wen_log.size() == 0; n++) @(negedge clk);
        check("rst_mid_first_beat", wen_log.size(), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_addr_q.delete(); exp_data_q.delete(); exp_b_q.delete();
        @(negedge clk);
        check("rst_mid_outputs", {awready, wready, bvalid, bram_wen, start_burst}, '0);
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", {awready, wready, bvalid, bram_waddr}, {1'b1, 1'b1, 1'b0, 10'h0});
        tick();
        clear_logs();
        send_burst(32'h100, 0, 1, 12'h077, -1);
        wait_drain();
        check_addrs("rst_mid_next_addr", '{32'h40});
        check("rst_mid_b_count", b_count, 1);

        // randomized bursts with random dev_ready/bready
        clear_logs();
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    dev_ready = ($urandom_range(3) != 0);
                    bready    = ($urandom_range(2) != 0);
                    tick();
                end
            end
            begin
                for (int k = 0; k < 20; k++)
                    send_burst($urandom, $urandom_range(15), $urandom_range(3), 12'($urandom), -1);
                wait_drain();
                rnd_on = 1'b0;
            end
        join
        dev_ready = 1'b1;
        bready    = 1'b1;
        tick(2);
        check("rand_b_count", b_count, 20);
        check("rand_queues_empty", exp_addr_q.size() + exp_data_q.size() + exp_b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
